// File: rtl/spi_regfile_if.sv
// SPI pin bundle for spi_regfile: master drives sclk/cs_n/sdi, target drives sdo.
interface spi_regfile_if;
  logic sclk;
  logic cs_n;
  logic sdi;
  logic sdo;

  modport master (output sclk, output cs_n, output sdi, input sdo);
  modport slave  (input sclk, input cs_n, input sdi, output sdo);
endinterface

// File: rtl/spi_regfile.sv
// SPI mode-0 target writing a bank of configuration registers from {rw, addr, data} frames.
// Define SPI_REGFILE_READBACK_EN to shift reg[addr] out on sdo during read frames.
module spi_regfile #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_regfile_if.slave               spi,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int LAST    = SYNC_STAGES - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_s, cs_s, sdi_s;
  logic                   sclk_d, cs_d;
  logic                   sclk_rise, cs_fall, cs_rise, sdi_bit;

  state_t               state;
  logic [FRAME_W-1:0]   sr;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_W-1:0]    bank [NUM_REGS];

  logic                 frame_rw;
  logic [ADDR_W-1:0]    frame_addr;
  logic [DATA_W-1:0]    frame_data;
  logic                 addr_ok, len_ok;

  // cs_n chain resets to 0 so a frame already running at reset release is never entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      cs_s   <= '0;
      sdi_s  <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], spi.sclk};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], spi.cs_n};
      sdi_s  <= {sdi_s[SYNC_STAGES-2:0], spi.sdi};
      sclk_d <= sclk_s[LAST];
      cs_d   <= cs_s[LAST];
    end
  end

  assign sclk_rise = sclk_s[LAST] & ~sclk_d;
  assign cs_fall   = ~cs_s[LAST] & cs_d;
  assign cs_rise   = cs_s[LAST] & ~cs_d;
  assign sdi_bit   = sdi_s[LAST];

  assign frame_rw   = sr[FRAME_W-1];
  assign frame_addr = sr[FRAME_W-2 -: ADDR_W];
  assign frame_data = sr[DATA_W-1:0];
  assign addr_ok    = {1'b0, frame_addr} < (ADDR_W+1)'(NUM_REGS);
  assign len_ok     = cnt == CNT_W'(FRAME_W);

`ifdef SPI_REGFILE_READBACK_EN
  logic              sclk_fall;
  logic [DATA_W-1:0] tx;
  logic [DATA_W-1:0] rd_word;

  assign sclk_fall = ~sclk_s[LAST] & sclk_d;

  // Address is still in the low bits of sr right after the 1+ADDR_W header bits
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (sr[ADDR_W-1:0] == ADDR_W'(i)) rd_word = bank[i];
    end
  end

  assign spi.sdo = tx[DATA_W-1];
`else
  assign spi.sdo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) bank[i] <= '0;
`ifdef SPI_REGFILE_READBACK_EN
      tx        <= '0;
`endif
    end else begin
      wr_strobe <= '0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state <= SHIFT;
            sr    <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            sr <= {sr[FRAME_W-2:0], sdi_bit};
            if (cnt != CNT_W'(FRAME_W + 1)) cnt <= cnt + CNT_W'(1);
          end
`ifdef SPI_REGFILE_READBACK_EN
          if (sclk_fall) begin
            if (cnt == CNT_W'(1 + ADDR_W) && !sr[ADDR_W]) tx <= rd_word;
            else                                          tx <= {tx[DATA_W-2:0], 1'b0};
          end
`endif
          if (cs_rise) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
`ifdef SPI_REGFILE_READBACK_EN
          tx    <= '0;
`endif
          if (len_ok && addr_ok) begin
            if (frame_rw) begin
              for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (frame_addr == ADDR_W'(i)) begin
                  bank[i]      <= frame_data;
                  wr_strobe[i] <= 1'b1;
                end
              end
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = bank[g];
  end

endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: writes, frame errors, reset mid-frame and readback.
module tb_spi_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] regs;
  logic [4:0]  wr_strobe;
  logic        frame_err;

  spi_regfile_if spi ();

  spi_regfile #(
    .NUM_REGS   (5),
    .ADDR_W     (7),
    .DATA_W     (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi      (spi),
    .regs     (regs),
    .wr_strobe(wr_strobe),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          strobe_cycles = 0;
  int          err_cycles = 0;
  logic [4:0]  last_strobe = '0;
  logic [7:0]  rx = '0;

  always @(negedge clk) begin
    if (wr_strobe !== 5'b0) begin
      strobe_cycles++;
      last_strobe = wr_strobe;
    end
    if (frame_err === 1'b1) err_cycles++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode 0: sdi set while sclk low; sdo captured just before rises 9..16
  task automatic send(input logic [31:0] bits, input int n, input bit close);
    spi.cs_n = 1'b0;
    #80;
    for (int i = n - 1; i >= 0; i--) begin
      spi.sdi = bits[i];
      #80;
      if (n - i >= 9 && n - i <= 16) rx = {rx[6:0], spi.sdo};
      spi.sclk = 1'b1;
      #80;
      spi.sclk = 1'b0;
    end
    #80;
    if (close) spi.cs_n = 1'b1;
  endtask

  initial begin
    int lat;
    spi.sclk = 1'b0;
    spi.cs_n = 1'b1;
    spi.sdi  = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_regs", 64'(regs), 64'h0);
    check("reset_strobe", 64'(wr_strobe), 64'h0);
    check("reset_frame_err", 64'(frame_err), 64'h0);
    check("reset_sdo", 64'(spi.sdo), 64'h0);

    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_cs_rise_ignored", 64'(err_cycles), 64'd0);

    // write addr 2 = 0xA5
    send(32'h82A5, 16, 1'b1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (wr_strobe !== 5'b0) begin
        lat = k;
        break;
      end
    end
    check("write_latency", 64'(lat), 64'd4);
    check("strobe_value", 64'(wr_strobe), 64'h04);
    @(posedge clk);
    #1;
    check("strobe_one_clk", 64'(wr_strobe), 64'h0);
    repeat (6) @(negedge clk);
    check("write2_regs", 64'(regs), 64'h00_00_A5_00_00);
    check("write2_no_err", 64'(err_cycles), 64'd0);
    check("write2_strobe_cycles", 64'(strobe_cycles), 64'd1);
    check("write2_last_strobe", 64'(last_strobe), 64'h04);

    // back-to-back writes with a 4 clk gap
    @(negedge clk);
    send(32'h8411, 16, 1'b1);
    repeat (4) @(negedge clk);
    send(32'h8022, 16, 1'b1);
    repeat (10) @(negedge clk);
    check("b2b_regs", 64'(regs), 64'h11_00_A5_00_22);
    check("b2b_strobe_cycles", 64'(strobe_cycles), 64'd3);
    check("b2b_no_err", 64'(err_cycles), 64'd0);

    // out-of-range address
    send(32'h85FF, 16, 1'b1);
    repeat (10) @(negedge clk);
    check("badaddr_err", 64'(err_cycles), 64'd1);
    check("badaddr_regs", 64'(regs), 64'h11_00_A5_00_22);
    check("badaddr_no_strobe", 64'(strobe_cycles), 64'd3);

    // short and long frames to addr 1
    send(32'h40BB, 15, 1'b1);
    repeat (10) @(negedge clk);
    check("short_err", 64'(err_cycles), 64'd2);
    send(32'h102EE, 17, 1'b1);
    repeat (10) @(negedge clk);
    check("long_err", 64'(err_cycles), 64'd3);
    check("len_regs", 64'(regs), 64'h11_00_A5_00_22);
    check("len_no_strobe", 64'(strobe_cycles), 64'd3);

    // read frame: accepted, no write, no error
    send(32'h0100, 16, 1'b1);
    repeat (10) @(negedge clk);
    check("read_no_err", 64'(err_cycles), 64'd3);
    check("read_no_strobe", 64'(strobe_cycles), 64'd3);

    // reset after 8 bits of a frame, then a clean write
    send(32'h8377, 8, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_regs", 64'(regs), 64'h0);
    check("midreset_strobe", 64'(wr_strobe), 64'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    spi.cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset_silent", 64'(err_cycles), 64'd3);
    send(32'h833C, 16, 1'b1);
    repeat (10) @(negedge clk);
    check("after_reset_regs", 64'(regs), 64'h00_3C_00_00_00);
    check("after_reset_strobe", 64'(last_strobe), 64'h08);
    check("after_reset_no_err", 64'(err_cycles), 64'd3);

    // readback of addr 1
    send(32'h815A, 16, 1'b1);
    repeat (10) @(negedge clk);
    check("rb_write_regs", 64'(regs), 64'h00_3C_00_5A_00);
    rx = '0;
    send(32'h0100, 16, 1'b1);
    repeat (10) @(negedge clk);
`ifdef SPI_REGFILE_READBACK_EN
    check("rb_sdo_bits", 64'(rx), 64'h5A);
`else
    check("rb_sdo_bits", 64'(rx), 64'h00);
`endif
    check("rb_sdo_idle", 64'(spi.sdo), 64'h0);
    check("rb_no_err", 64'(err_cycles), 64'd3);
    check("rb_strobe_cycles", 64'(strobe_cycles), 64'd5);
    check("rb_regs_hold", 64'(regs), 64'h00_3C_00_5A_00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
